// File: rtl/spio_hss_multiplexer_frame_tx_control.sv
// ----------------------------------------------------------------------------
// spio_hss_multiplexer_frame_tx_control
//
// Sliding-window transmit control for the HSS multiplexer frame path. The
// block hands out sequence numbers to new frames and picks the next frame to
// send. It retires frames on remote ACKs and rewinds on remote NAKs, which
// also flip the frame colour. When no progress is made it raises an
// out-of-credit (OOC) frame request.
//
// Pointers (all modulo 2^SEQ_BITS, ordered base <= snd <= nxt from base):
//   base : oldest unacknowledged frame
//   snd  : next frame to transmit
//   nxt  : next sequence number to assign
//
// Ports
//   clk, rst                  : clock, synchronous active-low reset
//   nfrm_vld / nfrm_rdy       : new frame offered / window has space
//   nfrm_seq                  : sequence number for the offered frame
//   tx_vld / tx_rdy           : frame ready to send / transmitter accepts
//   tx_seq, tx_colour         : sequence number and colour of frame to send
//   ack_vld, ack_type,
//   ack_colour, ack_seq       : remote ACK (type 1) / NAK (type 0)
//   ooc_rts / ooc_rdy         : out-of-credit frame request / accept
//   ooc_colour                : colour captured when the request was raised
//   reg_rack, reg_rnak,
//   reg_bad, reg_tout         : single-cycle event pulses to the register bank
// ----------------------------------------------------------------------------
module spio_hss_multiplexer_frame_tx_control #(
    parameter int SEQ_BITS = 7,
    parameter int WIN_BITS = 5,
    parameter int TOUT_CNT = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                nfrm_vld,
    output logic                nfrm_rdy,
    output logic [SEQ_BITS-1:0] nfrm_seq,

    output logic                tx_vld,
    input  logic                tx_rdy,
    output logic [SEQ_BITS-1:0] tx_seq,
    output logic                tx_colour,

    input  logic                ack_vld,
    input  logic                ack_type,
    input  logic                ack_colour,
    input  logic [SEQ_BITS-1:0] ack_seq,

    output logic                ooc_rts,
    input  logic                ooc_rdy,
    output logic                ooc_colour,

    output logic                reg_rack,
    output logic                reg_rnak,
    output logic                reg_bad,
    output logic                reg_tout
);

    localparam int                  CNT_BITS    = $clog2(TOUT_CNT + 1);
    localparam logic [SEQ_BITS-1:0] WIN_SIZE    = SEQ_BITS'(2 ** WIN_BITS);
    localparam logic [CNT_BITS-1:0] TOUT_RELOAD = CNT_BITS'(TOUT_CNT);

    logic [SEQ_BITS-1:0] base;
    logic [SEQ_BITS-1:0] snd;
    logic [SEQ_BITS-1:0] nxt;
    logic                colour;
    logic [CNT_BITS-1:0] tout_cnt;   // no-progress counter (frames in flight)
    logic [CNT_BITS-1:0] full_cnt;   // window-full counter

    // Offsets measured from base so that wrap-around needs no special case.
    logic [SEQ_BITS-1:0] in_window;
    logic [SEQ_BITS-1:0] ack_off;
    logic [SEQ_BITS-1:0] snd_off;

    logic good_ack;
    logic good_nak;
    logic dup_nak;
    logic bad_ack;
    logic pending;
    logic ooc_done;
    logic tout_hit;

    assign in_window = nxt - base;
    assign ack_off   = ack_seq - base;
    assign snd_off   = snd - base;

    assign nfrm_rdy  = (in_window != WIN_SIZE);
    assign nfrm_seq  = nxt;
    assign tx_vld    = (snd != nxt) && !ooc_rts;
    assign tx_seq    = snd;
    assign tx_colour = colour;

    // An ACK must retire at least one sent frame. A NAK may point anywhere
    // from base up to snd inclusive.
    assign good_ack = ack_vld &&  ack_type && (ack_colour == colour) &&
                      (ack_off != '0) && (ack_off <= snd_off);
    assign good_nak = ack_vld && !ack_type && (ack_colour != colour) &&
                      (ack_off <= snd_off);
    // The remote repeats a NAK it has already seen acted on: not an error.
    assign dup_nak  = ack_vld && !ack_type && (ack_colour == colour);
    assign bad_ack  = ack_vld && !good_ack && !good_nak && !dup_nak;

    assign pending  = (base != snd);
    assign ooc_done = ooc_rts && ooc_rdy;

    // Raise OOC once either counter has run out. Progress in the same cycle
    // wins, and a request already outstanding is not re-raised.
    assign tout_hit = !ooc_rts && !good_ack && !good_nak &&
                      ((pending && (tout_cnt == '0)) ||
                       (!nfrm_rdy && (full_cnt == '0)));

    // NOTE: state is updated with non-blocking assignments so every branch
    // below sees the pre-edge values of the pointers, whatever the order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            base       <= '0;
            snd        <= '0;
            nxt        <= '0;
            colour     <= 1'b0;
            tout_cnt   <= TOUT_RELOAD;
            full_cnt   <= TOUT_RELOAD;
            ooc_rts    <= 1'b0;
            ooc_colour <= 1'b0;
            reg_rack   <= 1'b0;
            reg_rnak   <= 1'b0;
            reg_bad    <= 1'b0;
            reg_tout   <= 1'b0;
        end else begin
            reg_rack <= good_ack;
            reg_rnak <= good_nak;
            reg_bad  <= bad_ack;
            reg_tout <= tout_hit;

            // Frame acceptance is independent of ack/nak handling.
            if (nfrm_vld && nfrm_rdy) begin
                nxt <= nxt + 1'b1;
            end

            // A good NAK rewinds snd and discards any same-cycle handshake.
            if (good_nak) begin
                base   <= ack_seq;
                snd    <= ack_seq;
                colour <= ~colour;
            end else begin
                if (tx_vld && tx_rdy) begin
                    snd <= snd + 1'b1;
                end
                if (good_ack) begin
                    base <= ack_seq;
                end
            end

            // The counters saturate at zero so an outstanding request does
            // not retrigger. They restart once the request is accepted.
            if (good_ack || good_nak || !pending || ooc_done) begin
                tout_cnt <= TOUT_RELOAD;
            end else if (tout_cnt != '0) begin
                tout_cnt <= tout_cnt - 1'b1;
            end

            if (nfrm_rdy || ooc_done) begin
                full_cnt <= TOUT_RELOAD;
            end else if (full_cnt != '0) begin
                full_cnt <= full_cnt - 1'b1;
            end

            if (good_nak || ooc_done) begin
                ooc_rts <= 1'b0;
            end else if (tout_hit) begin
                ooc_rts    <= 1'b1;
                ooc_colour <= colour;
            end
        end
    end

endmodule

// File: tb/tb_spio_hss_multiplexer_frame_tx_control.sv
// ----------------------------------------------------------------------------
// Testbench for spio_hss_multiplexer_frame_tx_control.
// Each accepted frame pushes its expected sequence number into a scoreboard.
// Each sent frame pops and compares against it. Ack/nak stimulus pushes the
// expected register-bank pulse pattern, which is popped one cycle later.
// ----------------------------------------------------------------------------
module tb_spio_hss_multiplexer_frame_tx_control;

    localparam int SEQ_BITS = 7;
    localparam int WIN_BITS = 5;
    localparam int TOUT_CNT = 255;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                nfrm_vld = 1'b0;
    logic                nfrm_rdy;
    logic [SEQ_BITS-1:0] nfrm_seq;
    logic                tx_vld;
    logic                tx_rdy = 1'b0;
    logic [SEQ_BITS-1:0] tx_seq;
    logic                tx_colour;
    logic                ack_vld = 1'b0;
    logic                ack_type = 1'b0;
    logic                ack_colour = 1'b0;
    logic [SEQ_BITS-1:0] ack_seq = '0;
    logic                ooc_rts;
    logic                ooc_rdy = 1'b0;
    logic                ooc_colour;
    logic                reg_rack;
    logic                reg_rnak;
    logic                reg_bad;
    logic                reg_tout;

    int checks = 0;
    int errors = 0;

    logic [SEQ_BITS-1:0] m_nxt;
    logic [SEQ_BITS-1:0] exp_tx_q[$];
    logic [3:0]          exp_ev_q[$];   // {rack, rnak, bad, tout}

    spio_hss_multiplexer_frame_tx_control #(
        .SEQ_BITS(SEQ_BITS),
        .WIN_BITS(WIN_BITS),
        .TOUT_CNT(TOUT_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .nfrm_vld  (nfrm_vld),
        .nfrm_rdy  (nfrm_rdy),
        .nfrm_seq  (nfrm_seq),
        .tx_vld    (tx_vld),
        .tx_rdy    (tx_rdy),
        .tx_seq    (tx_seq),
        .tx_colour (tx_colour),
        .ack_vld   (ack_vld),
        .ack_type  (ack_type),
        .ack_colour(ack_colour),
        .ack_seq   (ack_seq),
        .ooc_rts   (ooc_rts),
        .ooc_rdy   (ooc_rdy),
        .ooc_colour(ooc_colour),
        .reg_rack  (reg_rack),
        .reg_rnak  (reg_rnak),
        .reg_bad   (reg_bad),
        .reg_tout  (reg_tout)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=1000000", $time);
        $fatal(1);
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nfrm_vld = 1'b0; tx_rdy = 1'b0; ack_vld = 1'b0; ack_type = 1'b0;
        ack_colour = 1'b0; ack_seq = '0; ooc_rdy = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        m_nxt = '0;
        exp_tx_q.delete();
        exp_ev_q.delete();
    endtask

    task automatic accept(input int n);
        for (int i = 0; i < n; i++) begin
            nfrm_vld = 1'b1;
            checks++;
            if (nfrm_rdy !== 1'b1 || nfrm_seq !== m_nxt) begin
                errors++;
                $display("FAIL accept: nfrm_rdy=%b nfrm_seq=%0d, expected nfrm_rdy=1 nfrm_seq=%0d",
                         nfrm_rdy, nfrm_seq, m_nxt);
            end
            exp_tx_q.push_back(m_nxt);
            tick();
            m_nxt++;
        end
        nfrm_vld = 1'b0;
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            logic [SEQ_BITS-1:0] e;
            checks++;
            if (exp_tx_q.size() == 0) begin
                errors++;
                $display("FAIL send: tx_seq=%0d offered but no frame expected", tx_seq);
            end else begin
                e = exp_tx_q.pop_front();
                if (tx_vld !== 1'b1 || tx_seq !== e) begin
                    errors++;
                    $display("FAIL send: tx_vld=%b tx_seq=%0d, expected tx_vld=1 tx_seq=%0d",
                             tx_vld, tx_seq, e);
                end
            end
            tx_rdy = 1'b1;
            tick();
            tx_rdy = 1'b0;
        end
    endtask

    // Expected tx order after a rewind: every assigned frame from seq onward.
    task automatic rewind_to(input logic [SEQ_BITS-1:0] seq);
        logic [SEQ_BITS-1:0] s;
        s = seq;
        exp_tx_q.delete();
        while (s != m_nxt) begin
            exp_tx_q.push_back(s);
            s++;
        end
    endtask

    task automatic ack(input logic typ, input logic col, input logic [SEQ_BITS-1:0] seq,
                       input logic [3:0] exp_ev, input string name);
        logic [3:0] got;
        logic [3:0] e;
        ack_vld = 1'b1; ack_type = typ; ack_colour = col; ack_seq = seq;
        exp_ev_q.push_back(exp_ev);
        tick();
        ack_vld = 1'b0;
        got = {reg_rack, reg_rnak, reg_bad, reg_tout};
        e   = exp_ev_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: {rack,rnak,bad,tout}=%b, expected %b", name, got, e);
        end
        if (e == 4'b0100) rewind_to(seq);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({nfrm_rdy, tx_vld, ooc_rts, tx_colour} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: {nfrm_rdy,tx_vld,ooc_rts,tx_colour}=%b, expected 1000",
                     {nfrm_rdy, tx_vld, ooc_rts, tx_colour});
        end
        checks++;
        if (nfrm_seq !== 7'd0 || tx_seq !== 7'd0) begin
            errors++;
            $display("FAIL reset_seq: nfrm_seq=%0d tx_seq=%0d, expected 0 0", nfrm_seq, tx_seq);
        end
        checks++;
        if ({reg_rack, reg_rnak, reg_bad, reg_tout} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: %b, expected 0000", {reg_rack, reg_rnak, reg_bad, reg_tout});
        end
    endtask

    task automatic test_ack();
        do_reset();
        accept(3);
        send(3);
        checks++;
        if (tx_vld !== 1'b0) begin
            errors++;
            $display("FAIL ack_all_sent: tx_vld=%b, expected 0", tx_vld);
        end
        ack(1'b1, 1'b0, 7'd3, 4'b1000, "ack_seq3");
        checks++;
        if (tx_vld !== 1'b0 || nfrm_rdy !== 1'b1) begin
            errors++;
            $display("FAIL ack_after: tx_vld=%b nfrm_rdy=%b, expected 0 1", tx_vld, nfrm_rdy);
        end
        tick();
        checks++;
        if (reg_rack !== 1'b0) begin
            errors++;
            $display("FAIL ack_single_pulse: reg_rack=%b, expected 0", reg_rack);
        end
        // base is now 3, so ACK 3 retires nothing and ACK 2 is behind base.
        ack(1'b1, 1'b0, 7'd3, 4'b0010, "ack_seq3_again");
        ack(1'b1, 1'b0, 7'd2, 4'b0010, "ack_behind_base");
    endtask

    task automatic test_nak();
        do_reset();
        accept(5);
        send(5);
        ack(1'b0, 1'b1, 7'd2, 4'b0100, "nak_seq2");
        checks++;
        if (tx_colour !== 1'b1 || tx_seq !== 7'd2 || tx_vld !== 1'b1) begin
            errors++;
            $display("FAIL nak_rewind: colour=%b tx_seq=%0d tx_vld=%b, expected 1 2 1",
                     tx_colour, tx_seq, tx_vld);
        end
        ack(1'b0, 1'b1, 7'd2, 4'b0000, "nak_repeat");
        checks++;
        if (tx_colour !== 1'b1 || tx_seq !== 7'd2) begin
            errors++;
            $display("FAIL nak_repeat_state: colour=%b tx_seq=%0d, expected 1 2", tx_colour, tx_seq);
        end
        send(3);
        ack(1'b1, 1'b0, 7'd5, 4'b0010, "ack_wrong_colour");
        ack(1'b1, 1'b1, 7'd5, 4'b1000, "ack_seq5_colour1");
        // Nothing in flight: a NAK beyond snd is out of range.
        ack(1'b0, 1'b0, 7'd7, 4'b0010, "nak_out_of_range");
    endtask

    task automatic test_window();
        do_reset();
        accept(32);
        checks++;
        if (nfrm_rdy !== 1'b0 || nfrm_seq !== 7'd32) begin
            errors++;
            $display("FAIL window_full: nfrm_rdy=%b nfrm_seq=%0d, expected 0 32", nfrm_rdy, nfrm_seq);
        end
        nfrm_vld = 1'b1;
        tick();
        nfrm_vld = 1'b0;
        checks++;
        if (nfrm_seq !== 7'd32) begin
            errors++;
            $display("FAIL window_refuse: nfrm_seq=%0d, expected 32", nfrm_seq);
        end
        send(1);
        ack(1'b1, 1'b0, 7'd1, 4'b1000, "window_ack1");
        checks++;
        if (nfrm_rdy !== 1'b1) begin
            errors++;
            $display("FAIL window_reopen: nfrm_rdy=%b, expected 1", nfrm_rdy);
        end
    endtask

    task automatic test_timeout();
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        do_reset();
        accept(2);
        send(1);
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (ooc_rts === 1'b1) begin
                n = i;
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || n < 254 || n > 258) begin
            errors++;
            $display("FAIL timeout_cycles: ooc_rts after %0d cycles (seen=%b), expected 254..258",
                     n, seen);
        end
        checks++;
        if (ooc_colour !== 1'b0 || tx_vld !== 1'b0 || reg_tout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_raise: ooc_colour=%b tx_vld=%b reg_tout=%b, expected 0 0 1",
                     ooc_colour, tx_vld, reg_tout);
        end
        tick();
        checks++;
        if (ooc_rts !== 1'b1 || reg_tout !== 1'b0 || tx_vld !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hold: ooc_rts=%b reg_tout=%b tx_vld=%b, expected 1 0 0",
                     ooc_rts, reg_tout, tx_vld);
        end
        ooc_rdy = 1'b1;
        tick();
        ooc_rdy = 1'b0;
        checks++;
        if (ooc_rts !== 1'b0 || tx_vld !== 1'b1 || tx_seq !== 7'd1) begin
            errors++;
            $display("FAIL timeout_release: ooc_rts=%b tx_vld=%b tx_seq=%0d, expected 0 1 1",
                     ooc_rts, tx_vld, tx_seq);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 126; i++) begin
            accept(1);
            send(1);
            ack(1'b1, 1'b0, m_nxt, 4'b1000, "wrap_fill");
        end
        accept(3);   // 126, 127, 0
        send(3);
        checks++;
        if (tx_seq !== 7'd1 || tx_vld !== 1'b0) begin
            errors++;
            $display("FAIL wrap_snd: tx_seq=%0d tx_vld=%b, expected 1 0", tx_seq, tx_vld);
        end
        ack(1'b1, 1'b0, 7'd0, 4'b1000, "wrap_ack0");
        ack(1'b1, 1'b0, 7'd5, 4'b0010, "wrap_ack5_bad");
        checks++;
        if (tx_seq !== 7'd1 || nfrm_seq !== 7'd1) begin
            errors++;
            $display("FAIL wrap_unchanged: tx_seq=%0d nfrm_seq=%0d, expected 1 1", tx_seq, nfrm_seq);
        end
        // Accepted only if base stayed at 0 after the bad ACK.
        ack(1'b1, 1'b0, 7'd1, 4'b1000, "wrap_ack1");
    endtask

    task automatic test_nak_collision();
        logic [3:0] got;
        logic [3:0] e;
        do_reset();
        accept(5);
        send(3);
        checks++;
        if (tx_vld !== 1'b1 || tx_seq !== 7'd3) begin
            errors++;
            $display("FAIL collide_pre: tx_vld=%b tx_seq=%0d, expected 1 3", tx_vld, tx_seq);
        end
        tx_rdy = 1'b1; nfrm_vld = 1'b1;
        ack_vld = 1'b1; ack_type = 1'b0; ack_colour = 1'b1; ack_seq = 7'd1;
        exp_ev_q.push_back(4'b0100);
        tick();
        tx_rdy = 1'b0; nfrm_vld = 1'b0; ack_vld = 1'b0;
        m_nxt++;
        got = {reg_rack, reg_rnak, reg_bad, reg_tout};
        e   = exp_ev_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL collide_pulses: %b, expected %b", got, e);
        end
        checks++;
        if (tx_seq !== 7'd1 || tx_colour !== 1'b1 || nfrm_seq !== 7'd6) begin
            errors++;
            $display("FAIL collide_state: tx_seq=%0d colour=%b nfrm_seq=%0d, expected 1 1 6",
                     tx_seq, tx_colour, nfrm_seq);
        end
        rewind_to(7'd1);
        send(2);
        // Reset mid-stream discards everything in flight.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_nxt = '0;
        exp_tx_q.delete();
        checks++;
        if (nfrm_seq !== 7'd0 || tx_seq !== 7'd0 || tx_vld !== 1'b0 || nfrm_rdy !== 1'b1 ||
            tx_colour !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: nfrm_seq=%0d tx_seq=%0d tx_vld=%b nfrm_rdy=%b colour=%b, expected 0 0 0 1 0",
                     nfrm_seq, tx_seq, tx_vld, nfrm_rdy, tx_colour);
        end
        repeat (3) tick();
        checks++;
        if ({reg_rack, reg_rnak, reg_bad, reg_tout, ooc_rts} !== 5'b00000) begin
            errors++;
            $display("FAIL midreset_quiet: {rack,rnak,bad,tout,ooc_rts}=%b, expected 00000",
                     {reg_rack, reg_rnak, reg_bad, reg_tout, ooc_rts});
        end
    endtask

    initial begin
        test_reset();
        test_ack();
        test_nak();
        test_window();
        test_timeout();
        test_wrap();
        test_nak_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
